// File: rtl/branch_resolve_if.sv
// branch_resolve_if: op, result and redirect handshakes of the branch resolve unit.
interface branch_resolve_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [63:0] in_imm;
    logic [63:0] in_rs1;
    logic [63:0] in_cmp;
    logic        in_jump;
    logic        in_jalr;
    logic        in_pred_taken;
    logic [63:0] in_pred_target;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [63:0] out_target;
    logic [63:0] out_link;
    logic        redir_valid;
    logic        redir_ready;
    logic [63:0] redir_pc;
    logic        flush;
    modport master (
        output in_valid, in_pc, in_imm, in_rs1, in_cmp, in_jump, in_jalr, in_pred_taken, in_pred_target,
        output out_ready, redir_ready,
        input  in_ready, out_valid, out_taken, out_target, out_link, redir_valid, redir_pc, flush
    );
    modport slave (
        input  in_valid, in_pc, in_imm, in_rs1, in_cmp, in_jump, in_jalr, in_pred_taken, in_pred_target,
        input  out_ready, redir_ready,
        output in_ready, out_valid, out_taken, out_target, out_link, redir_valid, redir_pc, flush
    );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: resolves a branch op, reports its outcome and requests a fetch redirect on mispredict.
// Statistics counters are built only when BRU_STATS_EN is defined.
module branch_resolve #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_resolve_if.slave  bus,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t      r_state, w_next;
    logic        r_out_valid, r_out_taken, r_flush;
    logic [63:0] r_out_target, r_out_link, r_redir_pc;
    logic        w_taken, w_mis, w_accept;
    logic [63:0] w_target, w_link;
    assign w_taken  = bus.in_jump | bus.in_cmp[0];
    assign w_target = bus.in_jalr ? ((bus.in_rs1 + bus.in_imm) & ~64'h1) : (bus.in_pc + bus.in_imm);
    assign w_link   = bus.in_pc + 64'd4;
    assign w_mis    = (w_taken != bus.in_pred_taken) | (w_taken & (w_target != bus.in_pred_target));
    assign bus.in_ready = (r_state == IDLE) & (~r_out_valid | bus.out_ready);
    assign w_accept = bus.in_valid & bus.in_ready;
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? ((w_accept & w_mis) ? HOLD : IDLE) : (bus.redir_ready ? IDLE : HOLD);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_taken  <= 1'b0;
            r_out_target <= '0;
            r_out_link   <= '0;
            r_redir_pc   <= '0;
            r_flush      <= 1'b0;
        end else begin
            r_flush <= w_accept & w_mis;
            if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_out_taken  <= w_taken;
                r_out_target <= w_target;
                r_out_link   <= w_link;
            end else if (bus.out_ready) begin
                r_out_valid  <= 1'b0;
            end
            if (w_accept & w_mis) r_redir_pc <= w_taken ? w_target : w_link;
        end
    end
    // The redirect is outstanding exactly while the FSM waits in HOLD.
    assign bus.redir_valid = (r_state == HOLD);
    assign bus.redir_pc    = r_redir_pc;
    assign bus.flush       = r_flush;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_taken   = r_out_taken;
    assign bus.out_target  = r_out_target;
    assign bus.out_link    = r_out_link;
`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] r_br_cnt, r_mis_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (w_accept && !(&r_br_cnt)) r_br_cnt <= r_br_cnt + CNT_W'(1);
            if (w_accept && w_mis && !(&r_mis_cnt)) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
        end
    end
    assign br_cnt  = r_br_cnt;
    assign mis_cnt = r_mis_cnt;
`else
    assign br_cnt  = '0;
    assign mis_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and random ops against a queue-based reference model.
// The driver predicts results into queues; a negedge monitor checks whatever the DUT presents.
module tb_branch_resolve;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] br_cnt, mis_cnt;
    branch_resolve_if bus();
    branch_resolve #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .br_cnt(br_cnt), .mis_cnt(mis_cnt));
    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0;
    logic [128:0] out_q[$];
    logic [63:0]  redir_q[$];
    bit m_hold = 0, m_outv = 0;
    int m_br = 0, m_mis = 0;

    task automatic chk(input string nm, input logic [319:0] got, input logic [319:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] tgt(input logic jr, input logic [63:0] pc, imm, rs1);
        return jr ? ((rs1 + imm) & ~64'h1) : (pc + imm);
    endfunction

    // One clock of stimulus; the model predicts the effect of the coming edge.
    task automatic cyc(input logic v, input logic [63:0] pc, imm, rs1, cmp, input logic j, jr, pt,
                       input logic [63:0] ptg, input logic ordy, rrdy);
        bit exp_rdy, tk, mis;
        logic [63:0] tg;
        @(posedge clk); #2;
        bus.in_valid = v; bus.in_pc = pc; bus.in_imm = imm; bus.in_rs1 = rs1; bus.in_cmp = cmp;
        bus.in_jump = j; bus.in_jalr = jr; bus.in_pred_taken = pt; bus.in_pred_target = ptg;
        bus.out_ready = ordy; bus.redir_ready = rrdy;
        #1;
        exp_rdy = !m_hold && (!m_outv || ordy);
        chk("in_ready", 320'(bus.in_ready), 320'(exp_rdy));
        if (m_outv && ordy) m_outv = 0;
        if (m_hold && rrdy) m_hold = 0;
        if (v && exp_rdy) begin
            tk  = j | cmp[0];
            tg  = tgt(jr, pc, imm, rs1);
            mis = (tk != pt) || (tk && tg != ptg);
            out_q.push_back({tk, tg, pc + 64'd4});
            m_outv = 1;
            m_br++;
            if (mis) begin
                redir_q.push_back(tk ? tg : pc + 64'd4);
                m_hold = 1;
                m_mis++;
            end
        end
    endtask

    task automatic idle(input logic ordy, rrdy);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, ordy, rrdy);
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {bus.out_valid, bus.redir_valid, bus.flush, bus.out_taken, bus.out_target,
                 bus.out_link, bus.redir_pc, br_cnt, mis_cnt}, '0);
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk_zero("reset_async");
        out_q.delete(); redir_q.delete();
        m_hold = 0; m_outv = 0; m_br = 0; m_mis = 0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1;
    endtask

    task automatic chk_cnt;
`ifdef BRU_STATS_EN
        chk("br_cnt", 320'(br_cnt), 320'(m_br));
        chk("mis_cnt", 320'(mis_cnt), 320'(m_mis));
`else
        chk("br_cnt", 320'(br_cnt), 320'(0));
        chk("mis_cnt", 320'(mis_cnt), 320'(0));
`endif
    endtask

    initial begin : monitor
        bit prev_rv = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rv = 0;
                continue;
            end
            chk("flush", 320'(bus.flush), 320'(bus.redir_valid && !prev_rv));
            if (bus.out_valid) begin
                if (out_q.size() == 0) chk("out_spurious", 320'(1), 320'(0));
                else begin
                    chk("out_data", {bus.out_taken, bus.out_target, bus.out_link}, 320'(out_q[0]));
                    if (bus.out_ready) void'(out_q.pop_front());
                end
            end
            if (bus.redir_valid) begin
                if (redir_q.size() == 0) chk("redir_spurious", 320'(1), 320'(0));
                else begin
                    chk("redir_pc", 320'(bus.redir_pc), 320'(redir_q[0]));
                    if (bus.redir_ready) void'(redir_q.pop_front());
                end
            end
            prev_rv = bus.redir_valid;
        end
    end

    initial begin : driver
        logic [63:0] pc, imm, rs1, cmp, ptg, tg;
        logic j, jr, tk, pt;
        bus.in_valid = 0; bus.in_pc = 0; bus.in_imm = 0; bus.in_rs1 = 0; bus.in_cmp = 0;
        bus.in_jump = 0; bus.in_jalr = 0; bus.in_pred_taken = 0; bus.in_pred_target = 0;
        bus.out_ready = 1; bus.redir_ready = 1;
        #1;
        chk_zero("reset_init");
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1;
        // not-taken, correctly predicted
        cyc(1, 64'h1000, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1, 1);
        // taken mispredict; redirect held for three cycles
        cyc(1, 64'h1000, 64'h40, 0, '1, 0, 0, 0, 0, 1, 0);
        repeat (3) cyc(1, 64'h2000, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1, 1);
        idle(1, 1);
        // JALR: correct target, then wrong target
        cyc(1, 0, 64'h4, 64'h2003, 0, 1, 1, 1, 64'h2006, 1, 1);
        cyc(1, 0, 64'h4, 64'h2003, 0, 1, 1, 1, 64'h2004, 1, 1);
        idle(1, 1);
        idle(1, 1);
        // wrap-around of link and target
        cyc(1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 0, '1, 0, 0, 1, 64'h4, 1, 1);
        idle(1, 1);
        // output backpressure, then back-to-back accepts
        cyc(1, 64'h3000, 64'h10, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) cyc(1, 64'h3100, 64'h10, 0, '1, 0, 0, 1, 64'h3110, 0, 1);
        repeat (3) cyc(1, 64'h3200, 64'h20, 0, '1, 0, 0, 1, 64'h3220, 1, 1);
        idle(1, 1);
        // reset in the middle of HOLD
        cyc(1, 64'h4000, 64'h80, 0, '1, 0, 0, 0, 0, 1, 0);
        idle(1, 0);
        do_reset();
        // three branches, one mispredict
        cyc(1, 64'h5000, 64'h8, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(1, 64'h5004, 64'h8, 0, '1, 0, 0, 1, 64'h500C, 1, 1);
        cyc(1, 64'h5008, 64'h8, 0, '1, 0, 0, 0, 0, 1, 1);
        repeat (3) idle(1, 1);
        chk_cnt();
        for (int i = 0; i < 1500; i++) begin
            pc  = {$urandom, $urandom};
            rs1 = {$urandom, $urandom};
            imm = ($urandom % 2) ? {{52{pc[11]}}, pc[11:0]} : {$urandom, $urandom};
            cmp = ($urandom % 3 == 0) ? {$urandom, $urandom} : (($urandom % 2) ? '1 : '0);
            j   = ($urandom % 4 == 0);
            jr  = j & $urandom_range(0, 1);
            tk  = j | cmp[0];
            tg  = tgt(jr, pc, imm, rs1);
            pt  = ($urandom % 5 == 0) ? !tk : tk;
            ptg = ($urandom % 5 == 0) ? {$urandom, $urandom} : tg;
            cyc($urandom % 4 != 0, pc, imm, rs1, cmp, j, jr, pt, ptg, $urandom % 4 != 0, $urandom % 3 == 0);
            if (i == 700) do_reset();
        end
        repeat (4) idle(1, 1);
        chk("drain_out", 320'(out_q.size()), 320'(0));
        chk("drain_redir", 320'(redir_q.size()), 320'(0));
        chk_cnt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
